// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - FIR coefficient stream loader with shadow/active bank commit
module fir_coeff_loader #(
    parameter int DATA_WIDTH = 24,
    parameter int FIR_DEPTH  = 16,
    localparam int IW = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic [DATA_WIDTH-1:0]           iv_coeff,
    input  logic                            i_coeff_valid,
    output logic                            o_coeff_ready,
    output logic [FIR_DEPTH*DATA_WIDTH-1:0] ov_weights,
    output logic                            o_weights_valid,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [IW-1:0]                   ov_index
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(FIR_DEPTH - 1);

    state_t                state;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shadow [FIR_DEPTH];

    // Ready and busy are pure decodes of the registered state.
    always_comb begin
        o_coeff_ready = (state == LOAD);
        o_busy        = (state != IDLE);
        ov_index      = idx;
    end

    // Load FSM: assemble words into the shadow bank, then copy the whole set to the active bank in one edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            idx             <= '0;
            o_done          <= 1'b0;
            o_weights_valid <= 1'b0;
            ov_weights      <= '0;
            for (int k = 0; k < FIR_DEPTH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    // Abort takes priority over a beat in the same cycle, including the final one.
                    if (i_abort) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (i_coeff_valid) begin
                        shadow[idx] <= iv_coeff;
                        if (idx == LAST_IDX) begin
                            state <= COMMIT;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                COMMIT: begin
                    for (int k = 0; k < FIR_DEPTH; k++) begin
                        ov_weights[k*DATA_WIDTH +: DATA_WIDTH] <= shadow[k];
                    end
                    o_done          <= 1'b1;
                    o_weights_valid <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
